mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: BEATS, 4, words per cache-line burst (power of two, 2..16).
REQ-002 Parameter: AW, 32, address width in bits.
REQ-003 Port: CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: RESET  in  1  asynchronous, active-high reset.
REQ-005 Port: i_req  in  1  I-cache line-refill request; held high until i_done.
REQ-006 Port: i_addr  in  AW  I-cache miss address.
REQ-007 Port: i_rdata  out  32  refill data to I-cache; i_valid  out  1  beat strobe; i_done  out  1  last-beat pulse.
REQ-008 Port: d_req  in  1  D-cache request; d_we  in  1  1=writeback, 0=refill.
REQ-009 Port: d_addr  in  AW  D-cache address; d_wdata  in  32  writeback word for the current beat.
REQ-010 Port: d_rdata  out  32  refill data; d_valid  out  1  beat strobe; d_beat  out  log2(BEATS)  current beat index; d_done  out  1  last-beat pulse.
REQ-011 Port: mem_req  out  1  memory request; mem_we  out  1  write; mem_addr  out  AW  word address; mem_wdata  out  32  write data.
REQ-012 Port: mem_ack  in  1  beat accepted/completed; mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-013 Port: StallF  out  1  freeze fetch; StallM  out  1  freeze memory stage (to hazard logic).

Function
REQ-014 FSM states IDLE, GRANT_I, GRANT_D; one grant active at a time.
REQ-015 IDLE: d_req=1 -> GRANT_D; else i_req=1 -> GRANT_I; else stay (fixed priority, D over I).
REQ-016 On grant entry, latch base = addr with low log2(BEATS)+2 bits zeroed, plus d_we (D grant only); beat counter = 0.
REQ-017 In grant: mem_req=1, mem_addr = base + 4*beat (modulo 2^AW), mem_we = latched d_we (0 for I), mem_wdata = d_wdata.
REQ-018 Beat advances only on a cycle with mem_ack=1; mem_req stays high and mem_addr stable until then.
REQ-019 On ack of a read beat: owner's rdata = mem_rdata and valid=1 for exactly that cycle; write beats assert no valid.
REQ-020 On ack of beat BEATS-1: owner's done=1 for one cycle, FSM -> IDLE; at least one IDLE cycle between bursts.
REQ-021 Requester de-asserting req mid-burst is ignored; the burst completes all BEATS.
REQ-022 mem_ack while IDLE is ignored.
REQ-023 StallF = i_req AND NOT i_done; StallM = d_req AND NOT d_done (combinational).
REQ-024 Latency: first mem_req is one cycle after req seen in IDLE; burst length = BEATS acks.

Reset
REQ-025 RESET=1 forces IDLE, beat=0, latches cleared, mem_req/mem_we/valids/dones = 0, all data/addr outputs 0, immediately and regardless of CLK.
REQ-026 Reset mid-burst abandons the burst; no done is issued; pending req re-arbitrated after release.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: a last-grant flag (reset to I) gives, when both request in IDLE, the grant to the requester not last served; flag updated on grant.
REQ-028 Macro not defined: fixed priority per REQ-015; no last-grant state present.

Verification
REQ-029 d_req=0, i_req=1, i_addr=0x0000_1234 -> mem_addr 0x1230,0x1234,0x1238,0x123C on successive acks; 4 i_valid; i_done on 4th ack; StallF falls with i_done.
REQ-030 i_req and d_req rise together (d_we=0, d_addr=0x2000), fixed priority -> D burst 0x2000..0x200C first, one IDLE cycle, then I burst.
REQ-031 d_we=1, d_addr=0x3000, d_wdata = 0xA0+d_beat, mem_ack every 3rd cycle -> mem_we=1, wdata 0xA0..0xA3 at addresses 0x3000..0x300C, address held between acks, no d_valid, d_done once.
REQ-032 RESET pulsed after 2nd ack of an I burst -> all outputs 0 asynchronously, no i_done; i_req still high -> new burst restarts at beat 0.
REQ-033 d_addr=0xFFFF_FFF8 -> base 0xFFFF_FFF0, addresses wrap within 32 bits, no overflow side effects.
REQ-034 ARB_ROUND_ROBIN_EN, both requesters held high continuously -> grants alternate D, I, D, I.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: I-cache, D-cache and memory-side handshakes.
// master = arbiter view, slave = requester/memory environment view.
interface mem_port_arbiter_if #(
  parameter int BEATS = 4,
  parameter int AW    = 32
);
  logic                       i_req;
  logic [AW-1:0]              i_addr;
  logic [31:0]                i_rdata;
  logic                       i_valid;
  logic                       i_done;

  logic                       d_req;
  logic                       d_we;
  logic [AW-1:0]              d_addr;
  logic [31:0]                d_wdata;
  logic [31:0]                d_rdata;
  logic                       d_valid;
  logic [$clog2(BEATS)-1:0]   d_beat;
  logic                       d_done;

  logic                       mem_req;
  logic                       mem_we;
  logic [AW-1:0]              mem_addr;
  logic [31:0]                mem_wdata;
  logic                       mem_ack;
  logic [31:0]                mem_rdata;

  logic                       StallF;
  logic                       StallM;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_rdata, i_valid, i_done, d_rdata, d_valid, d_beat, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, StallF, StallM
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_rdata, i_valid, i_done, d_rdata, d_valid, d_beat, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, StallF, StallM
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by I-cache refills and D-cache refills/writebacks, one burst at a time.
// ARB_ROUND_ROBIN_EN: alternate grants when both caches request; otherwise D always wins.
module mem_port_arbiter #(
  parameter int BEATS = 4,
  parameter int AW    = 32
) (
  input  logic CLK,
  input  logic RESET,
  mem_port_arbiter_if.master bus
);
  localparam int BW = $clog2(BEATS);
  localparam logic [AW-1:0] LINE_MASK = {{(AW-BW-2){1'b1}}, {(BW+2){1'b0}}};

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] base_q, base_d;
  logic          we_q, we_d;
  logic          pick_d;
  logic          in_grant, last_beat, i_ack, d_ack;

  assign in_grant  = (state_q != IDLE);
  assign last_beat = (beat_q == BW'(BEATS-1));
  assign i_ack     = (state_q == GRANT_I) && bus.mem_ack;
  assign d_ack     = (state_q == GRANT_D) && bus.mem_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;  // 1 = D-cache was the most recent grant

  assign pick_d = bus.d_req && (!bus.i_req || !last_d_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) last_d_q <= 1'b0;
    else       last_d_q <= last_d_d;
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE) begin
      if (pick_d)          last_d_d = 1'b1;
      else if (bus.i_req)  last_d_d = 1'b0;
    end
  end
`else
  assign pick_d = bus.d_req;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = GRANT_D;
          base_d  = bus.d_addr & LINE_MASK;
          we_d    = bus.d_we;
          beat_d  = '0;
        end else if (bus.i_req) begin
          state_d = GRANT_I;
          base_d  = bus.i_addr & LINE_MASK;
          we_d    = 1'b0;
          beat_d  = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        // Requests dropping mid-burst are ignored: only acks move the burst along.
        if (bus.mem_ack) begin
          if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = in_grant;
  assign bus.mem_we    = (state_q == GRANT_D) && we_q;
  assign bus.mem_addr  = in_grant ? base_q + {{(AW-BW-2){1'b0}}, beat_q, 2'b00} : '0;
  assign bus.mem_wdata = in_grant ? bus.d_wdata : 32'h0;

  assign bus.i_valid = i_ack;
  assign bus.i_rdata = i_ack ? bus.mem_rdata : 32'h0;
  assign bus.i_done  = i_ack && last_beat;

  assign bus.d_valid = d_ack && !we_q;
  assign bus.d_rdata = (d_ack && !we_q) ? bus.mem_rdata : 32'h0;
  assign bus.d_done  = d_ack && last_beat;
  assign bus.d_beat  = (state_q == GRANT_D) ? beat_q : '0;

  assign bus.StallF = bus.i_req && !bus.i_done;
  assign bus.StallM = bus.d_req && !bus.d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected beats queued at stimulus time, popped on each ack.
module tb_mem_port_arbiter;
  localparam int BEATS = 4;
  localparam int AW    = 32;
  localparam logic [31:0] RD_XOR = 32'h5A5A_0000;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        is_d;
    logic        last;
  } beat_t;

  logic CLK;
  logic RESET;
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  beat_t exp_q[$];

  mem_port_arbiter_if #(.BEATS(BEATS), .AW(AW)) b ();
  mem_port_arbiter #(.BEATS(BEATS), .AW(AW)) dut (.CLK(CLK), .RESET(RESET), .bus(b.master));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "watchdog");
  end

  // One clock: memory model acks every 'period'th cycle and returns addr^RD_XOR;
  // the writeback source supplies 0xA0+d_beat.
  task automatic cyc(input int period);
    @(negedge CLK);
    cyc_cnt++;
    b.mem_ack   = ((cyc_cnt % period) == 0);
    b.mem_rdata = b.mem_ack ? (b.mem_addr ^ RD_XOR) : 32'h0;
    b.d_wdata   = 32'hA0 + 32'(b.d_beat);
    #1;
  endtask

  task automatic push_burst(input logic [31:0] base, input logic is_d, input logic we);
    for (int k = 0; k < BEATS; k++)
      exp_q.push_back('{addr: base + 32'(4*k), we: we, wdata: 32'hA0 + 32'(k),
                        is_d: is_d, last: (k == BEATS-1)});
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    b.i_req = 0; b.i_addr = '0; b.d_req = 0; b.d_we = 0; b.d_addr = '0;
    b.d_wdata = '0; b.mem_ack = 1'b1; b.mem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge CLK);
    #1;
    tests++;
    if ({b.mem_req, b.mem_we, b.i_valid, b.i_done, b.d_valid, b.d_done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {b.mem_req, b.mem_we, b.i_valid, b.i_done, b.d_valid, b.d_done});
    end
    tests++;
    if (b.mem_addr !== 32'h0 || b.i_rdata !== 32'h0 || b.d_rdata !== 32'h0 || b.d_beat !== 2'd0) begin
      fails++;
      $display("FAIL reset_data: addr=%h i_rdata=%h d_rdata=%h d_beat=%0d expected all 0",
               b.mem_addr, b.i_rdata, b.d_rdata, b.d_beat);
    end
    @(negedge CLK);
    RESET = 1'b0; b.mem_ack = 0; b.mem_rdata = 0;
  endtask

  task automatic test_ack_idle();
    int bad = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      if (b.mem_req !== 0 || b.i_valid !== 0 || b.d_valid !== 0 || b.i_done !== 0 || b.d_done !== 0)
        bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL ack_idle: %0d cycles with activity, expected 0", bad);
    end
    b.mem_ack = 0;
  endtask

  task automatic test_i_burst();
    beat_t e;
    int dones = 0;
    exp_q.delete();
    push_burst(32'h0000_1230, 1'b0, 1'b0);
    b.i_addr = 32'h0000_1234; b.i_req = 1'b1;
    #1;
    tests++;
    if (b.mem_req !== 1'b0 || b.StallF !== 1'b1) begin
      fails++;
      $display("FAIL i_latency: mem_req=%b StallF=%b expected 0,1", b.mem_req, b.StallF);
    end
    for (int c = 0; c < 40 && dones == 0; c++) begin
      cyc(1);
      if (b.mem_req && b.mem_ack) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL i_extra_beat: addr=%h expected no beat", b.mem_addr);
          break;
        end
        e = exp_q.pop_front();
        tests++;
        if (b.mem_addr !== e.addr || b.mem_we !== 1'b0 || b.i_valid !== 1'b1 ||
            b.i_rdata !== (e.addr ^ RD_XOR) || b.d_valid !== 1'b0) begin
          fails++;
          $display("FAIL i_beat: addr=%h we=%b iv=%b rd=%h dv=%b expected addr=%h we=0 iv=1 rd=%h dv=0",
                   b.mem_addr, b.mem_we, b.i_valid, b.i_rdata, b.d_valid, e.addr, e.addr ^ RD_XOR);
        end
        tests++;
        if (b.i_done !== e.last || b.StallF !== !e.last) begin
          fails++;
          $display("FAIL i_done_stall: i_done=%b StallF=%b expected %b,%b", b.i_done, b.StallF, e.last, !e.last);
        end
        if (b.i_done) dones++;
      end
    end
    b.i_req = 1'b0;
    tests++;
    if (dones != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL i_burst_end: dones=%0d left=%0d expected 1,0", dones, exp_q.size());
    end
  endtask

  task automatic test_priority();
    beat_t e;
    int gap_chk = 0;
    exp_q.delete();
    push_burst(32'h0000_2000, 1'b1, 1'b0);
    push_burst(32'h0000_4000, 1'b0, 1'b0);
    b.d_addr = 32'h0000_2000; b.d_we = 1'b0; b.i_addr = 32'h0000_4000;
    b.d_req = 1'b1; b.i_req = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      cyc(1);
      if (gap_chk) begin
        gap_chk = 0;
        tests++;
        if (b.mem_req !== 1'b0) begin
          fails++;
          $display("FAIL prio_gap: mem_req=%b expected 0", b.mem_req);
        end
      end
      if (b.mem_req && b.mem_ack) begin
        e = exp_q.pop_front();
        tests++;
        if (b.mem_addr !== e.addr || b.d_valid !== e.is_d || b.i_valid !== !e.is_d ||
            (e.is_d ? b.d_rdata : b.i_rdata) !== (e.addr ^ RD_XOR)) begin
          fails++;
          $display("FAIL prio_beat: addr=%h dv=%b iv=%b expected addr=%h dv=%b iv=%b",
                   b.mem_addr, b.d_valid, b.i_valid, e.addr, e.is_d, !e.is_d);
        end
        tests++;
        if ((e.is_d ? b.d_done : b.i_done) !== e.last) begin
          fails++;
          $display("FAIL prio_done: done=%b expected %b at %h", e.is_d ? b.d_done : b.i_done, e.last, e.addr);
        end
        if (e.last && e.is_d) begin b.d_req = 1'b0; gap_chk = 1; end
        if (e.last && !e.is_d) b.i_req = 1'b0;
      end
    end
    b.d_req = 1'b0; b.i_req = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL prio_timeout: %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic test_writeback();
    beat_t e;
    int dones = 0, held_bad = 0;
    exp_q.delete();
    push_burst(32'h0000_3000, 1'b1, 1'b1);
    b.d_addr = 32'h0000_3000; b.d_we = 1'b1; b.d_req = 1'b1;
    cyc_cnt = 0;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      cyc(3);
      if (b.mem_req && exp_q.size() != 0 && b.mem_addr !== exp_q[0].addr) held_bad++;
      if (b.mem_req && b.mem_ack) begin
        e = exp_q.pop_front();
        tests++;
        if (b.mem_we !== 1'b1 || b.mem_wdata !== e.wdata || b.d_valid !== 1'b0 || b.d_done !== e.last) begin
          fails++;
          $display("FAIL wb_beat: we=%b wdata=%h dv=%b done=%b expected 1,%h,0,%b",
                   b.mem_we, b.mem_wdata, b.d_valid, b.d_done, e.wdata, e.last);
        end
        if (b.d_done) begin dones++; b.d_req = 1'b0; b.d_we = 1'b0; end
      end
    end
    b.d_req = 1'b0; b.d_we = 1'b0;
    tests++;
    if (held_bad != 0 || dones != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wb_summary: addr_unheld=%0d dones=%0d left=%0d expected 0,1,0", held_bad, dones, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    beat_t e;
    int acks = 0, dones = 0, first_ok = 0;
    exp_q.delete();
    push_burst(32'h0000_5000, 1'b0, 1'b0);
    b.i_addr = 32'h0000_5008; b.i_req = 1'b1;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      cyc(1);
      if (b.mem_req && b.mem_ack) begin
        e = exp_q.pop_front();
        acks++;
        if (b.i_done) dones++;
      end
    end
    b.mem_ack = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    tests++;
    if (b.mem_req !== 0 || b.mem_addr !== 32'h0 || b.i_done !== 0 || b.StallF !== 1'b1) begin
      fails++;
      $display("FAIL rst_async: mem_req=%b addr=%h i_done=%b StallF=%b expected 0,0,0,1",
               b.mem_req, b.mem_addr, b.i_done, b.StallF);
    end
    b.mem_ack = 1'b1;
    #1;
    tests++;
    if (b.i_valid !== 0 || b.i_done !== 0 || b.i_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_ack_ignored: iv=%b done=%b rd=%h expected 0,0,0", b.i_valid, b.i_done, b.i_rdata);
    end
    @(negedge CLK);
    RESET = 1'b0; b.mem_ack = 1'b0;
    exp_q.delete();
    push_burst(32'h0000_5000, 1'b0, 1'b0);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      cyc(1);
      if (b.mem_req && b.mem_ack) begin
        e = exp_q.pop_front();
        if (e.addr == 32'h0000_5000 && b.mem_addr === 32'h0000_5000) first_ok = 1;
        tests++;
        if (b.mem_addr !== e.addr || b.i_done !== e.last) begin
          fails++;
          $display("FAIL rst_restart: addr=%h done=%b expected %h,%b", b.mem_addr, b.i_done, e.addr, e.last);
        end
        if (b.i_done) begin dones++; b.i_req = 1'b0; end
      end
    end
    b.i_req = 1'b0;
    tests++;
    if (first_ok != 1 || dones != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rst_summary: first_ok=%0d dones=%0d left=%0d expected 1,1,0", first_ok, dones, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    beat_t e;
    int k = 0;
    exp_q.delete();
    push_burst(32'hFFFF_FFF0, 1'b1, 1'b0);
    b.d_addr = 32'hFFFF_FFF8; b.d_we = 1'b0; b.d_req = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      cyc(2);
      if (b.mem_req && b.mem_ack) begin
        e = exp_q.pop_front();
        tests++;
        if (b.mem_addr !== e.addr || b.d_beat !== 2'(k) || b.d_rdata !== (e.addr ^ RD_XOR) ||
            b.d_valid !== 1'b1 || b.d_done !== e.last) begin
          fails++;
          $display("FAIL wrap_beat: addr=%h beat=%0d rd=%h dv=%b done=%b expected %h,%0d,%h,1,%b",
                   b.mem_addr, b.d_beat, b.d_rdata, b.d_valid, b.d_done, e.addr, k, e.addr ^ RD_XOR, e.last);
        end
        k++;
        if (e.last) b.d_req = 1'b0;
      end
    end
    b.d_req = 1'b0;
    cyc(1);
    tests++;
    if (b.mem_req !== 1'b0 || b.StallM !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_end: mem_req=%b StallM=%b left=%0d expected 0,0,0", b.mem_req, b.StallM, exp_q.size());
    end
    b.mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int gap_chk = 0, done_cnt = 0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
    push_burst(32'h0000_6000, 1'b1, 1'b0);
    push_burst(32'h0000_7000, 1'b0, 1'b0);
    push_burst(32'h0000_6000, 1'b1, 1'b0);
    push_burst(32'h0000_7000, 1'b0, 1'b0);
`else
    for (int n = 0; n < 4; n++) push_burst(32'h0000_6000, 1'b1, 1'b0);
`endif
    b.d_addr = 32'h0000_6004; b.i_addr = 32'h0000_700C; b.d_we = 1'b0;
    b.d_req = 1'b1; b.i_req = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      cyc(1);
      if (gap_chk) begin
        gap_chk = 0;
        tests++;
        if (b.mem_req !== 1'b0) begin
          fails++;
          $display("FAIL b2b_gap: mem_req=%b expected 0", b.mem_req);
        end
      end
      if (b.mem_req && b.mem_ack) begin
        e = exp_q.pop_front();
        tests++;
        if (b.mem_addr !== e.addr || b.d_valid !== e.is_d || b.i_valid !== !e.is_d ||
            (e.is_d ? b.d_done : b.i_done) !== e.last) begin
          fails++;
          $display("FAIL b2b_beat: addr=%h dv=%b iv=%b expected addr=%h dv=%b iv=%b last=%b",
                   b.mem_addr, b.d_valid, b.i_valid, e.addr, e.is_d, !e.is_d, e.last);
        end
        if (e.last) begin gap_chk = 1; done_cnt++; end
      end
    end
    b.d_req = 1'b0; b.i_req = 1'b0;
    tests++;
    if (done_cnt != 4 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_summary: bursts=%0d left=%0d expected 4,0", done_cnt, exp_q.size());
    end
    cyc(1);
    b.mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ack_idle();
    test_i_burst();
    test_priority();
    test_writeback();
    test_reset_mid_burst();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
